// File: rtl/bit_destuff.sv
// Receive-side CAN bit destuffer: removes the complementary stuff bit that follows
// every run of THRESH identical bits and flags a stuff error when it is missing.
module bit_destuff #(
    parameter int THRESH = 5,
    parameter int CNT_W  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sample_valid,
    input  logic             rx_bit,
    output logic             data_out,
    output logic             data_valid,
    output logic             stuff_drop,
    output logic             stuff_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] run_count
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        EXPECT,
        ERROR
    } state_t;

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] run_d;
    logic             last_q;
    logic             last_d;
    logic [CNT_W-1:0] run_inc;

    logic dout_d;
    logic dv_d;
    logic drop_d;
    logic err_d;
    logic sticky_d;

    // Saturating increment: the run length never wraps past THRESH.
    assign run_inc = (run_count >= THRESH_C) ? THRESH_C : run_count + ONE_C;

    // State register and registered outputs.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, regardless of statement order.
        if (reset) begin
            state_q    <= IDLE;
            run_count  <= '0;
            last_q     <= 1'b1;
            data_out   <= 1'b1;
            data_valid <= 1'b0;
            stuff_drop <= 1'b0;
            stuff_err  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_count  <= run_d;
            last_q     <= last_d;
            data_out   <= dout_d;
            data_valid <= dv_d;
            stuff_drop <= drop_d;
            stuff_err  <= err_d;
            err_sticky <= sticky_d;
        end
    end

    // Next-state and run tracking.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        run_d   = run_count;
        last_d  = last_q;

        if (!enable) begin
            // Leaving the stuffing region discards any history, including a
            // pending stuff expectation at the end of the CRC sequence.
            state_d = IDLE;
            run_d   = '0;
            last_d  = 1'b1;
        end else if (sample_valid) begin
            unique case (state_q)
                IDLE: begin
                    state_d = COUNT;
                    run_d   = ONE_C;
                    last_d  = rx_bit;
                end
                COUNT: begin
                    if (rx_bit == last_q) begin
                        run_d = run_inc;
                    end else begin
                        run_d  = ONE_C;
                        last_d = rx_bit;
                    end
                    if (run_d == THRESH_C) begin
                        state_d = EXPECT;
                    end
                end
                EXPECT: begin
                    if (rx_bit != last_q) begin
                        // The stuff bit itself opens the next run.
                        state_d = COUNT;
                        run_d   = ONE_C;
                        last_d  = rx_bit;
                    end else begin
                        state_d = ERROR;
                    end
                end
                ERROR: begin
                    state_d = ERROR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output decode; data_out holds its last value when nothing is emitted.
    always_comb begin
        dout_d   = data_out;
        dv_d     = 1'b0;
        drop_d   = 1'b0;
        err_d    = 1'b0;
        sticky_d = err_sticky;

        if (!enable) begin
            sticky_d = 1'b0;
            if (sample_valid) begin
                dv_d   = 1'b1;
                dout_d = rx_bit;
            end
        end else if (sample_valid) begin
            unique case (state_q)
                IDLE, COUNT: begin
                    dv_d   = 1'b1;
                    dout_d = rx_bit;
                end
                EXPECT: begin
                    if (rx_bit != last_q) begin
                        drop_d = 1'b1;
                    end else begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                    end
                end
                ERROR: begin
                    dv_d = 1'b0;
                end
                default: begin
                    dv_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_destuff.sv
// Directed bench for bit_destuff (THRESH=5): each task drives one scenario and
// compares registered outputs one clock after every sample, at the falling edge.
module tb_bit_destuff;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       sample_valid;
    logic       rx_bit;
    logic       data_out;
    logic       data_valid;
    logic       stuff_drop;
    logic       stuff_err;
    logic       err_sticky;
    logic [3:0] run_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    bit_destuff #(
        .THRESH(5),
        .CNT_W (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .sample_valid(sample_valid),
        .rx_bit      (rx_bit),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .stuff_drop  (stuff_drop),
        .stuff_err   (stuff_err),
        .err_sticky  (err_sticky),
        .run_count   (run_count)
    );

    // Drive one sample for one clock; on return the registered response is visible.
    task automatic sample(input logic en, input logic b);
        enable       = en;
        sample_valid = 1'b1;
        rx_bit       = b;
        @(negedge clock);
        sample_valid = 1'b0;
    endtask

    task automatic gap();
        enable       = 1'b0;
        sample_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        rx_bit       = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (data_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_data_out: got %b expected 1", data_out);
        end
        checks++;
        if ({data_valid, stuff_drop, stuff_err, err_sticky} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {data_valid, stuff_drop, stuff_err, err_sticky});
        end
        checks++;
        if (run_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_run_count: got %0d expected 0", run_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_passthrough();
        logic b [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            sample(1'b0, b[i]);
            checks++;
            if (data_valid !== 1'b1 || data_out !== b[i]) begin
                errors++;
                $display("FAIL passthrough[%0d]: got valid=%b data=%b expected valid=1 data=%b",
                         i, data_valid, data_out, b[i]);
            end
            checks++;
            if (run_count !== 4'd0) begin
                errors++;
                $display("FAIL passthrough_run[%0d]: got %0d expected 0", i, run_count);
            end
        end
        gap();
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL passthrough_idle_valid: got %b expected 0", data_valid);
        end
    endtask

    task automatic test_no_stuffing();
        logic b [6]       = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int   exp_run [6] = '{1, 1, 1, 2, 1, 2};
        gap();
        for (int i = 0; i < 6; i++) begin
            sample(1'b1, b[i]);
            checks++;
            if (data_valid !== 1'b1 || data_out !== b[i] || stuff_drop !== 1'b0) begin
                errors++;
                $display("FAIL no_stuff[%0d]: got valid=%b data=%b drop=%b expected 1 %b 0",
                         i, data_valid, data_out, stuff_drop, b[i]);
            end
            checks++;
            if (run_count !== 4'(exp_run[i])) begin
                errors++;
                $display("FAIL no_stuff_run[%0d]: got %0d expected %0d", i, run_count, exp_run[i]);
            end
        end
    endtask

    task automatic test_dominant_run();
        logic b [7]        = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic exp_dv [7]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic exp_drop [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int   exp_run [7]  = '{1, 2, 3, 4, 5, 1, 1};
        gap();
        for (int i = 0; i < 7; i++) begin
            sample(1'b1, b[i]);
            checks++;
            if (data_valid !== exp_dv[i] || stuff_drop !== exp_drop[i] || stuff_err !== 1'b0) begin
                errors++;
                $display("FAIL dominant[%0d]: got valid=%b drop=%b err=%b expected %b %b 0",
                         i, data_valid, stuff_drop, stuff_err, exp_dv[i], exp_drop[i]);
            end
            if (exp_dv[i]) begin
                checks++;
                if (data_out !== 1'b0) begin
                    errors++;
                    $display("FAIL dominant_data[%0d]: got %b expected 0", i, data_out);
                end
            end
            checks++;
            if (run_count !== 4'(exp_run[i])) begin
                errors++;
                $display("FAIL dominant_run[%0d]: got %0d expected %0d", i, run_count, exp_run[i]);
            end
        end
        sample_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (data_valid !== 1'b0 || stuff_drop !== 1'b0 || run_count !== 4'd1) begin
            errors++;
            $display("FAIL dominant_hold: got valid=%b drop=%b run=%0d expected 0 0 1",
                     data_valid, stuff_drop, run_count);
        end
    endtask

    task automatic test_violation();
        logic exp_dv [6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic exp_err [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic more [4]    = '{1'b1, 1'b0, 1'b1, 1'b0};
        gap();
        for (int i = 0; i < 6; i++) begin
            sample(1'b1, 1'b1);
            checks++;
            if (data_valid !== exp_dv[i] || stuff_err !== exp_err[i] || stuff_drop !== 1'b0) begin
                errors++;
                $display("FAIL violation[%0d]: got valid=%b err=%b drop=%b expected %b %b 0",
                         i, data_valid, stuff_err, stuff_drop, exp_dv[i], exp_err[i]);
            end
        end
        checks++;
        if (err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL violation_sticky: got %b expected 1", err_sticky);
        end
        for (int i = 0; i < 4; i++) begin
            sample(1'b1, more[i]);
            checks++;
            if (data_valid !== 1'b0 || stuff_err !== 1'b0 || stuff_drop !== 1'b0 || err_sticky !== 1'b1) begin
                errors++;
                $display("FAIL error_hold[%0d]: got valid=%b err=%b drop=%b sticky=%b expected 0 0 0 1",
                         i, data_valid, stuff_err, stuff_drop, err_sticky);
            end
        end
        gap();
        checks++;
        if (err_sticky !== 1'b0 || run_count !== 4'd0) begin
            errors++;
            $display("FAIL error_clear: got sticky=%b run=%0d expected 0 0", err_sticky, run_count);
        end
    endtask

    task automatic test_stuff_starts_run();
        logic b [11]        = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic exp_drop [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int   n_dv   = 0;
        int   n_drop = 0;
        gap();
        for (int i = 0; i < 11; i++) begin
            sample(1'b1, b[i]);
            if (data_valid === 1'b1) n_dv++;
            if (stuff_drop === 1'b1) n_drop++;
            checks++;
            if (stuff_drop !== exp_drop[i] || stuff_err !== 1'b0) begin
                errors++;
                $display("FAIL next_run[%0d]: got drop=%b err=%b expected %b 0",
                         i, stuff_drop, stuff_err, exp_drop[i]);
            end
        end
        checks++;
        if (n_dv != 9 || n_drop != 2) begin
            errors++;
            $display("FAIL next_run_totals: got valid=%0d drops=%0d expected 9 2", n_dv, n_drop);
        end
    endtask

    task automatic test_enable_drop_expect();
        gap();
        for (int i = 0; i < 5; i++) sample(1'b1, 1'b1);
        checks++;
        if (run_count !== 4'd5) begin
            errors++;
            $display("FAIL en_drop_run: got %0d expected 5", run_count);
        end
        sample(1'b0, 1'b1);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 1'b1 || stuff_err !== 1'b0 ||
            stuff_drop !== 1'b0 || err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL en_drop_pass: got valid=%b data=%b err=%b drop=%b sticky=%b expected 1 1 0 0 0",
                     data_valid, data_out, stuff_err, stuff_drop, err_sticky);
        end
        checks++;
        if (run_count !== 4'd0) begin
            errors++;
            $display("FAIL en_drop_clear: got %0d expected 0", run_count);
        end
    endtask

    task automatic test_mid_reset();
        gap();
        for (int i = 0; i < 5; i++) sample(1'b1, 1'b0);
        reset        = 1'b1;
        enable       = 1'b1;
        sample_valid = 1'b1;
        rx_bit       = 1'b0;
        @(negedge clock);
        reset        = 1'b0;
        sample_valid = 1'b0;
        checks++;
        if (run_count !== 4'd0 || data_out !== 1'b1 ||
            {data_valid, stuff_drop, stuff_err, err_sticky} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset: got run=%0d data=%b flags=%b expected 0 1 0000",
                     run_count, data_out, {data_valid, stuff_drop, stuff_err, err_sticky});
        end
        // From IDLE the first sample is plain data, not a stuff check.
        sample(1'b1, 1'b0);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 1'b0 || stuff_drop !== 1'b0 || run_count !== 4'd1) begin
            errors++;
            $display("FAIL mid_reset_restart: got valid=%b data=%b drop=%b run=%0d expected 1 0 0 1",
                     data_valid, data_out, stuff_drop, run_count);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_no_stuffing();
        test_dominant_run();
        test_violation();
        test_stuff_starts_run();
        test_enable_drop_expect();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_destuff.md
Name: bit_destuff

Overview:
- Receive-side CAN bit destuffer; counterpart to the transmit-side stuff-run detector.
- Consumes sampled bus bits from the bit-timing logic and drops the stuff bit inserted after every run of THRESH identical bits.
- Passes the remaining bits on as a qualified stream to the frame deserialiser and CRC.
- Reports a stuff error to the error-management block when the expected stuff bit is missing.

Parameters:
- THRESH, 5, number of consecutive identical bits after which exactly one complementary stuff bit is expected (legal range 2..15).
- CNT_W, 4, width of the run counter; must satisfy 2**CNT_W > THRESH.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  stuffing region active (SOF through CRC sequence). Low means bits pass through unchecked.
- sample_valid  input  1  one-cycle strobe, one per sampled bus bit.
- rx_bit  input  1  sampled bus level, valid when sample_valid=1.
- data_out  output  1  destuffed bit.
- data_valid  output  1  one-cycle strobe qualifying data_out.
- stuff_drop  output  1  one-cycle pulse when a stuff bit is removed.
- stuff_err  output  1  one-cycle pulse on a stuff violation.
- err_sticky  output  1  held high from a violation until reset or enable falls.
- run_count  output  CNT_W  current run length (debug/verification visibility).

Behaviour:
- Reset (synchronous, dominates all other inputs):
  - state=IDLE, run_count=0, last bit=1 (recessive).
  - data_out=1; data_valid, stuff_drop, stuff_err, err_sticky all 0.
- Registered outputs: each is a function of the sample_valid cycle and appears exactly 1 clock later. Pulse outputs are high for exactly one clock.
- Cycles with sample_valid=0: no state change; all pulse outputs 0.
- State machine: IDLE, COUNT, EXPECT, ERROR.
- IDLE (enable=0):
  - Every sample passes through: data_valid=1, data_out=rx_bit.
  - No run tracking.
- IDLE to COUNT: first sample with enable=1.
  - That bit is data: run_count=1, last=rx_bit.
- COUNT, on each sample (always emitted as data):
  - rx_bit==last: run_count+1.
  - rx_bit!=last: run_count=1, last=rx_bit.
  - When the updated run_count equals THRESH, go to EXPECT.
- EXPECT, on each sample:
  - rx_bit!=last: the bit is a stuff bit and is dropped. data_valid=0, stuff_drop=1, last=rx_bit, run_count=1, go to COUNT. The stuff bit starts the next run.
  - rx_bit==last: stuff_err=1, err_sticky=1, data_valid=0, go to ERROR.
- ERROR:
  - All further samples are ignored; data_valid=0, no further pulses.
  - Held until enable=0 (go to IDLE, err_sticky cleared) or reset.
- enable falling in any state:
  - Go to IDLE and clear run_count the next clock.
  - A sample arriving in the same cycle that enable is low is treated as IDLE pass-through.
- enable falling while in EXPECT: no error; the pending stuff expectation is discarded. This covers a CRC sequence that ends on a run of THRESH.
- enable low then high again: restart from COUNT with run_count=1; no history is carried over.
- run_count saturates at THRESH and never wraps.

Test Plan:
- No stuffing:
  - Stimulus: THRESH=5, enable=1, bits 0,1,0,0,1,1.
  - Response: 6 data_valid pulses with data_out matching the input; no stuff_drop; final run_count=2.
- Dominant run with stuff bit:
  - Stimulus: bits 0,0,0,0,0,1,0.
  - Response: 6 data_valid pulses (0,0,0,0,0,0). stuff_drop pulses on the 6th sample (the 1), exactly 1 clock after it. run_count=1 after the stuff bit, then 1 after the final 0.
- Stuff violation:
  - Stimulus: bits 1×6.
  - Response: 5 data_valid pulses; stuff_err pulses on the 6th sample and err_sticky=1.
  - Continuation: a further 4 samples give no data_valid. Dropping enable clears err_sticky on the next clock.
- Stuff bit starts the next run:
  - Stimulus: 0×5, 1 (stuff), 1,1,1,1, 0 (stuff).
  - Response: two stuff_drop pulses; 9 data_valid pulses total. The second stuff is expected after only four data 1s, because the stuff bit counted as the first bit of that run.
- enable drop during EXPECT:
  - Stimulus: 1×5, enable=0, then sample 1.
  - Response: no stuff_err; the sample passes through with data_valid=1 and data_out=1.
- Mid-operation reset:
  - Stimulus: reset asserted in EXPECT with sample_valid=1 in the same cycle.
  - Response: next clock run_count=0, state IDLE, no pulse outputs.
